// File: rtl/kt_seq_pkg.sv
// Shared types for the command sequence checker: FSM states, error codes and
// default acknowledge bytes.
package kt_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_NEXT,
    ST_FINISH,
    ST_FAIL
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SENT_TO = 3'd1,
    ERR_ACK_TO  = 3'd2,
    ERR_NAK     = 3'd3,
    ERR_ABORT   = 3'd4
  } seq_err_e;

  localparam logic [7:0] DEF_POS_ACK = 8'hA5;
  localparam logic [7:0] DEF_NAK     = 8'h5A;

endpackage

// File: rtl/seq_timer.sv
// Saturating wait-state timer. expired is high in the cycle during which the
// number of cycles spent in the current wait state reaches LIMIT.
module seq_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_eff;

  // cnt_eff includes the current cycle, so the first cycle of a state reads 1
  always_comb begin
    cnt_eff = clr ? W'(1) : cnt;
    expired = en && (cnt_eff == LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!en)             cnt <= '0;
    else if (cnt_eff != LIM)  cnt <= cnt_eff + W'(1);
    else                      cnt <= cnt_eff;
  end

endmodule

// File: rtl/cmd_seq_checker.sv
// Issues a programmed list of 16-bit commands to the UART command wrapper and
// checks each response byte against POS_ACK, with timeout and NAK retry.
//
// state      | meaning
// IDLE       | waiting for start, command memory writable
// SEND       | drive cmd and pulse send_cmd
// WAIT_SENT  | waiting for cmd_sent rising edge
// WAIT_ACK   | waiting for response byte
// NEXT       | advance to the next command
// FINISH     | done is high for this one cycle
// FAIL       | error fields are valid, returning to IDLE
module cmd_seq_checker
  import kt_seq_pkg::*;
#(
  parameter int         NUM_CMDS       = 16,
  parameter int         TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0] POS_ACK        = DEF_POS_ACK,
  parameter int         MAX_RETRY      = 2,
  parameter int         IDX_W          = $clog2(NUM_CMDS + 1)
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [15:0]      wr_data,
  input  logic [IDX_W-1:0] seq_len,
  input  logic             start,
  input  logic             abort,
  output logic [15:0]      cmd,
  output logic             send_cmd,
  input  logic             cmd_sent,
  input  logic [7:0]       resp,
  input  logic             resp_rdy,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] cmds_ok
);

  localparam int AW     = (NUM_CMDS < 2) ? 1 : $clog2(NUM_CMDS);
  localparam int RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0]  NUM_L   = IDX_W'(NUM_CMDS);
  localparam logic [RTRY_W-1:0] RETRY_L = RTRY_W'(MAX_RETRY);

  seq_state_e        state, state_q;
  logic [15:0]       mem [NUM_CMDS];
  logic [IDX_W-1:0]  idx, len;
  logic [RTRY_W-1:0] retry;
  logic              cmd_sent_q, resp_rdy_q, resp_pend;
  logic              sent_rise, resp_rise, tmr_expired, tmr_en, tmr_clr;

  assign sent_rise = cmd_sent & ~cmd_sent_q;
  assign resp_rise = resp_rdy & ~resp_rdy_q;
  assign busy      = (state != ST_IDLE);
  assign tmr_en    = (state == ST_WAIT_SENT) || (state == ST_WAIT_ACK);
  assign tmr_clr   = (state != state_q);

  seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (RST_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (wr_en && !busy && (wr_addr < NUM_L))
      mem[wr_addr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state      <= ST_IDLE;
      state_q    <= ST_IDLE;
      cmd        <= '0;
      send_cmd   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      err_idx    <= '0;
      cmds_ok    <= '0;
      idx        <= '0;
      len        <= '0;
      retry      <= '0;
      cmd_sent_q <= 1'b0;
      resp_rdy_q <= 1'b0;
      resp_pend  <= 1'b0;
    end else begin
      state_q    <= state;
      send_cmd   <= 1'b0;
      done       <= 1'b0;
      cmd_sent_q <= cmd_sent;
      resp_rdy_q <= resp_rdy;

      // error fields are written on the edge entering FAIL so they are valid there
      if (abort && state != ST_IDLE && state != ST_FAIL) begin
        state     <= ST_FAIL;
        error     <= 1'b1;
        err_code  <= ERR_ABORT;
        err_idx   <= idx;
        resp_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cmd <= '0;
            if (start) begin
              error     <= 1'b0;
              err_code  <= ERR_NONE;
              cmds_ok   <= '0;
              idx       <= '0;
              retry     <= '0;
              resp_pend <= 1'b0;
              if (seq_len == '0) begin
                state <= ST_FINISH;
                done  <= 1'b1;
              end else begin
                len   <= (seq_len > NUM_L) ? NUM_L : seq_len;
                state <= ST_SEND;
              end
            end
          end
          ST_SEND: begin
            cmd      <= mem[idx[AW-1:0]];
            send_cmd <= 1'b1;
            state    <= ST_WAIT_SENT;
          end
          ST_WAIT_SENT: begin
            if (resp_rise) resp_pend <= 1'b1;
            if (sent_rise) begin
              state <= ST_WAIT_ACK;
            end else if (tmr_expired) begin
              state     <= ST_FAIL;
              error     <= 1'b1;
              err_code  <= ERR_SENT_TO;
              err_idx   <= idx;
              resp_pend <= 1'b0;
            end
          end
          ST_WAIT_ACK: begin
            if (resp_pend || resp_rise) begin
              resp_pend <= 1'b0;
              if (resp == POS_ACK) begin
                cmds_ok <= cmds_ok + 1'b1;
                state   <= ST_NEXT;
              end else if (retry < RETRY_L) begin
                retry <= retry + 1'b1;
                state <= ST_SEND;
              end else begin
                state    <= ST_FAIL;
                error    <= 1'b1;
                err_code <= ERR_NAK;
                err_idx  <= idx;
              end
            end else if (tmr_expired) begin
              state    <= ST_FAIL;
              error    <= 1'b1;
              err_code <= ERR_ACK_TO;
              err_idx  <= idx;
            end
          end
          ST_NEXT: begin
            idx   <= idx + 1'b1;
            retry <= '0;
            if (idx + 1'b1 == len) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state <= ST_SEND;
            end
          end
          ST_FINISH: state <= ST_IDLE;
          ST_FAIL:   state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_seq_checker.sv
// Randomised bench for cmd_seq_checker: a wrapper model answers each send_cmd
// and a per-command outcome model predicts sends, acks and the final status.
module tb_cmd_seq_checker;

  localparam int NUM_CMDS  = 8;
  localparam int TO        = 1000;
  localparam int MAX_RETRY = 2;
  localparam int IDX_W     = $clog2(NUM_CMDS + 1);
  localparam logic [7:0] ACK = 8'hA5;

  typedef enum int {K_ACK, K_ACK_SAME, K_NAK, K_NOSENT, K_NORESP, K_ABORT} kind_e;

  logic             clk, RST_n, wr_en, start, abort, cmd_sent, resp_rdy;
  logic [IDX_W-1:0] wr_addr, seq_len, err_idx, cmds_ok;
  logic [15:0]      wr_data, cmd;
  logic [7:0]       resp;
  logic             send_cmd, busy, done, error;
  logic [2:0]       err_code;

  cmd_seq_checker #(
    .NUM_CMDS(NUM_CMDS), .TIMEOUT_CYCLES(TO), .POS_ACK(ACK), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .RST_n(RST_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp(resp), .resp_rdy(resp_rdy), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_idx(err_idx), .cmds_ok(cmds_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  int n_send, n_done;
  logic [15:0] mem_m [NUM_CMDS];
  kind_e scn_q[$];

  always @(negedge clk) begin
    if (send_cmd) n_send++;
    if (done)     n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic write_mem(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = d;
    if (a < NUM_CMDS) mem_m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < NUM_CMDS; i++) write_mem(i, 16'($urandom));
    write_mem(NUM_CMDS + int'($urandom_range(0, (1 << IDX_W) - NUM_CMDS - 1)), 16'($urandom));
  endtask

  function automatic kind_e pick_kind();
    int p;
    if (scn_q.size() > 0) return scn_q.pop_front();
    p = int'($urandom_range(0, 99));
    if (p < 55) return K_ACK;
    if (p < 65) return K_ACK_SAME;
    if (p < 85) return K_NAK;
    if (p < 90) return K_NOSENT;
    if (p < 95) return K_NORESP;
    return K_ABORT;
  endfunction

  task automatic run_seq(input int len_req, input bit wr_at_start);
    int n, i, a, k, d1, r, exp_ok, exp_sends, exp_code, exp_idx, wa;
    bit failed, first;
    kind_e kd;
    logic [7:0] rb;
    n = (len_req > NUM_CMDS) ? NUM_CMDS : len_req;
    @(negedge clk);
    start = 1'b1; seq_len = IDX_W'(len_req);
    n_send = 0; n_done = 0;
    if (wr_at_start) begin
      wa = int'($urandom_range(0, NUM_CMDS - 1));
      wr_en = 1'b1; wr_addr = IDX_W'(wa); wr_data = 16'($urandom);
      mem_m[wa] = wr_data;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; seq_len = IDX_W'($urandom);
    if (n == 0) begin
      chk("len0_done_next_cycle", done, 1);
      @(negedge clk);
      chk("len0_sends", n_send, 0);
      chk("len0_done_count", n_done, 1);
      chk("len0_error", error, 0);
      return;
    end
    i = 0; a = 0; failed = 0; first = 1;
    exp_ok = 0; exp_sends = 0; exp_code = 0; exp_idx = 0;
    while (i < n && !failed) begin
      k = 0;
      while (!send_cmd && k < 20) begin @(negedge clk); k++; end
      if (!send_cmd) begin
        chk("send_cmd_wait", send_cmd, 1);
        failed = 1; exp_code = -1;
        break;
      end
      exp_sends++;
      chk($sformatf("cmd[%0d]", i), cmd, mem_m[i]);
      kd = pick_kind();
      if (kd == K_NOSENT) begin
        k = 0;
        while (!error && k < TO + 50) begin @(negedge clk); k++; end
        chk("sent_timeout_cycles", k, TO);
        failed = 1; exp_code = 1; exp_idx = i;
      end else begin
        d1 = int'($urandom_range(0, 3));
        r  = (kd == K_ACK_SAME) ? 0 : (kd == K_NORESP || kd == K_ABORT) ? -1
             : int'($urandom_range(0, 3));
        rb = (kd == K_NAK) ? 8'($urandom) : ACK;
        if (rb == ACK && kd == K_NAK) rb = 8'h5A;
        for (int t = 0; t <= d1 + ((r < 0) ? 2 : r); t++) begin
          @(negedge clk);
          cmd_sent = (t == d1);
          if (r >= 0 && t == d1 + r) begin resp = rb; resp_rdy = 1'b1; end
          else resp_rdy = 1'b0;
          abort = (kd == K_ABORT) && (t == d1 + 2);
          // write while busy must be ignored
          wr_en = first && (t == 0);
          wr_addr = IDX_W'($urandom_range(0, NUM_CMDS - 1));
          wr_data = 16'($urandom);
        end
        @(negedge clk);
        cmd_sent = 1'b0; resp_rdy = 1'b0; abort = 1'b0; wr_en = 1'b0;
        case (kd)
          K_ACK, K_ACK_SAME: begin exp_ok++; i++; a = 0; end
          K_NAK: begin
            if (a < MAX_RETRY) a++;
            else begin failed = 1; exp_code = 3; exp_idx = i; end
          end
          K_NORESP: begin failed = 1; exp_code = 2; exp_idx = i; end
          default:  begin failed = 1; exp_code = 4; exp_idx = i; end
        endcase
      end
      first = 0;
    end
    k = 0;
    while (busy && k < 3000) begin @(negedge clk); k++; end
    chk("busy_fall", busy, 0);
    chk("cmds_ok", cmds_ok, exp_ok);
    chk("error", error, failed);
    if (exp_code >= 0) chk("err_code", err_code, exp_code);
    if (failed && exp_code >= 0) chk("err_idx", err_idx, exp_idx);
    chk("done_count", n_done, failed ? 0 : 1);
    chk("send_count", n_send, exp_sends);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_send_cmd"}, send_cmd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_idx"}, err_idx, 0);
    chk({tag, "_cmds_ok"}, cmds_ok, 0);
  endtask

  initial begin
    int k;
    RST_n = 1'b0; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
    wr_addr = '0; wr_data = '0; seq_len = '0;
    n_send = 0; n_done = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    RST_n = 1'b1;

    write_mem(0, 16'h2000); write_mem(1, 16'h4001); write_mem(2, 16'h6002);
    scn_q = '{K_ACK, K_ACK, K_ACK};
    run_seq(3, 1'b0);

    scn_q = '{K_NOSENT};
    run_seq(1, 1'b0);

    scn_q = '{K_NAK, K_NAK, K_ACK};
    run_seq(1, 1'b0);
    scn_q = '{K_NAK, K_NAK, K_NAK};
    run_seq(1, 1'b0);

    scn_q = '{K_ACK_SAME};
    run_seq(1, 1'b0);

    scn_q = '{K_ACK, K_NORESP};
    run_seq(2, 1'b0);

    scn_q = '{K_ACK, K_ABORT};
    run_seq(3, 1'b0);
    scn_q = '{K_ACK, K_ACK, K_ACK};
    run_seq(3, 1'b0);

    run_seq(0, 1'b0);

    // asynchronous reset while waiting for cmd_sent
    @(negedge clk); start = 1'b1; seq_len = IDX_W'(2);
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!send_cmd && k < 20) begin @(negedge clk); k++; end
    chk("rst_test_send", send_cmd, 1);
    @(negedge clk);
    #2 RST_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk); RST_n = 1'b1;

    load_random();
    for (int run = 0; run < 30; run++) begin
      if (run % 6 == 5) load_random();
      run_seq(int'($urandom_range(0, NUM_CMDS + 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_seq_checker.md
Name: cmd_seq_checker

Overview:
- Synthesizable, parametrised successor to the bench-side send-command / check-ack flow.
- Holds a programmable list of up to NUM_CMDS 16-bit commands and issues them in order to the UART command wrapper.
- For each command, waits for cmd_sent, then for a response byte; compares it against POS_ACK with timeout and NAK-retry, and reports progress and first-failure status.
- Sits between a host or self-test controller and the remote-command UART wrapper, for on-chip tour scripting and hardware self-check.

Parameters:
- NUM_CMDS, 16: depth of the command memory (≥1).
- TIMEOUT_CYCLES, 50000000: clocks allowed in each wait state before a timeout.
- POS_ACK, 8'hA5: byte that counts as a positive acknowledge.
- MAX_RETRY, 2: resends allowed per command after a non-POS_ACK response (0 = no retry).
- IDX_W, $clog2(NUM_CMDS+1): width of the length and index fields.

Ports:
- clk  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write command memory (ignored while busy).
- wr_addr  in  IDX_W  write address (values ≥ NUM_CMDS ignored).
- wr_data  in  16  command word to write.
- seq_len  in  IDX_W  number of commands to run; sampled on start.
- start  in  1  begin sequence (ignored while busy).
- abort  in  1  stop the sequence immediately.
- cmd  out  16  command to UART wrapper.
- send_cmd  out  1  one-cycle send strobe.
- cmd_sent  in  1  wrapper finished transmitting; edge-detected internally.
- resp  in  8  response byte.
- resp_rdy  in  1  response valid; edge-detected internally.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse: all commands acknowledged.
- error  out  1  sticky until next start: sequence failed.
- err_code  out  3  0 none, 1 sent-timeout, 2 ack-timeout, 3 NAK-exhausted, 4 aborted.
- err_idx  out  IDX_W  index of the failing command.
- cmds_ok  out  IDX_W  count of commands positively acknowledged.

Behaviour:
- Reset values: cmd=0, send_cmd=0, busy=0, done=0, error=0, err_code=0, err_idx=0, cmds_ok=0, FSM in IDLE, retry count 0, both edge-detect registers 0. The command memory is not reset.
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, NEXT, FINISH, FAIL.
- IDLE:
  - start with seq_len=0 → FINISH; done pulses the next cycle and nothing is sent.
  - start with seq_len>0 → clear error, err_code, cmds_ok, idx and retry; capture seq_len (clamped to NUM_CMDS); go to SEND.
- SEND: drive cmd=mem[idx], assert send_cmd for exactly one cycle, go to WAIT_SENT. send_cmd is high on the 2nd cycle after start is sampled. cmd holds stable from SEND until the next SEND or IDLE.
- WAIT_SENT:
  - cmd_sent rising edge → WAIT_ACK.
  - timer reaches TIMEOUT_CYCLES → FAIL, code 1.
  - A resp_rdy rising edge here (including the same cycle as cmd_sent) is latched as pending and consumed on entry to WAIT_ACK.
- WAIT_ACK (pending or new resp_rdy edge):
  - resp==POS_ACK → cmds_ok+1, go to NEXT.
  - resp≠POS_ACK and retry<MAX_RETRY → retry+1, go to SEND (same idx).
  - Otherwise → FAIL, code 3.
  - Timeout → FAIL, code 2.
- NEXT: idx+1 and retry=0. If idx+1==len → FINISH, else → SEND.
- FINISH: done pulses for one cycle, then IDLE.
- FAIL: set error, err_code and err_idx=idx, then IDLE. No done pulse.
- Timer rules:
  - Clears on every state entry and counts only in WAIT_SENT and WAIT_ACK.
  - Width $clog2(TIMEOUT_CYCLES+1); saturating, no wrap.
  - Timeout fires on the cycle the count equals TIMEOUT_CYCLES.
- abort: highest priority in any non-IDLE state → FAIL with code 4 next cycle; any send_cmd in flight is dropped. abort in IDLE is ignored.
- busy is high in every state except IDLE.
- start and wr_en while busy are ignored. A write to an address in the same cycle as start takes effect for that run.
- Asserting RST_n mid-sequence returns everything to reset values asynchronously.

Decomposition:
- Package kt_seq_pkg: state enum, err_code enum (ERR_NONE..ERR_ABORT), default POS_ACK/NAK constants.
- Sub-module seq_timer: parameter LIMIT; ports clr, en; output expired (saturating). One instance is shared by both wait states.

Test Plan:
- Load 3 commands (16'h2000, 16'h4001, 16'h6002), seq_len=3, start; wrapper returns cmd_sent and resp=8'hA5 each time. Required: 3 send_cmd pulses in order, cmds_ok=3, one done pulse, error=0.
- TIMEOUT_CYCLES=1000, cmd_sent never arrives. Required: error=1, err_code=1, err_idx=0 exactly 1000 cycles after WAIT_SENT entry; busy falls.
- MAX_RETRY=2, responses 8'h5A, 8'h5A, 8'hA5. Required: the same cmd is sent 3 times, then success. With 3×8'h5A: err_code=3, err_idx=0.
- resp_rdy edge arrives in the same cycle as cmd_sent with resp=8'hA5. Required: accepted, no ack timeout.
- abort asserted during WAIT_ACK of command 1. Required: err_code=4, err_idx=1, cmds_ok=1, no done. A new start then runs cleanly.
- seq_len=0 start → done pulse on the next cycle with no send_cmd. RST_n pulled low mid-WAIT_SENT → all outputs return to 0 immediately.
